// File: rtl/hub75_scan_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_scan_scheduler
//  Description : HUB75 panel scan sequencer using binary-code-modulation
//                bit-planes. For each plane it walks the framebuffer columns
//                (two cycles per column), then blanks, latches the row and
//                starts the display slot (OE_BASE_TICKS << plane cycles).
//                Shifting of the next plane overlaps the current display slot.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_in       in   system clock
//    reset_n      in   asynchronous active-low reset
//    enable       in   run scan, sampled in IDLE and at each latch
//    brightness   in   [7:0] global dimming (only with HUB75_GLOBAL_DIMMING_EN)
//    col_addr     out  framebuffer column being shifted
//    shift_row    out  framebuffer row being shifted
//    shift_plane  out  bit-plane being shifted
//    pixel_clk    out  panel shift clock
//    row_latch    out  panel latch strobe
//    oe_n         out  panel output enable, active-low
//    row_address  out  panel row select
//    frame_done   out  pulse at the latch of the last row/plane of a frame
//    busy         out  high whenever not idle
//  Build option
//    HUB75_GLOBAL_DIMMING_EN : adds brightness; only the first
//                              (slot*brightness)>>8 cycles of a slot are lit.
// ============================================================================
module hub75_scan_scheduler #(
    parameter int PIXEL_WIDTH      = 64,
    parameter int PIXEL_HALFHEIGHT = 16,
    parameter int BCM_BITS         = 6,
    parameter int OE_BASE_TICKS    = 32
) (
    input  logic                                clk_in,
    input  logic                                reset_n,
    input  logic                                enable,
`ifdef HUB75_GLOBAL_DIMMING_EN
    input  logic [7:0]                          brightness,
`endif
    output logic [$clog2(PIXEL_WIDTH)-1:0]      col_addr,
    output logic [$clog2(PIXEL_HALFHEIGHT)-1:0] shift_row,
    output logic [$clog2(BCM_BITS)-1:0]         shift_plane,
    output logic                                pixel_clk,
    output logic                                row_latch,
    output logic                                oe_n,
    output logic [$clog2(PIXEL_HALFHEIGHT)-1:0] row_address,
    output logic                                frame_done,
    output logic                                busy
);

    localparam int CW = $clog2(PIXEL_WIDTH);
    localparam int RW = $clog2(PIXEL_HALFHEIGHT);
    localparam int PW = $clog2(BCM_BITS);
    localparam int TW = $clog2(OE_BASE_TICKS << BCM_BITS);

    localparam logic [CW-1:0] C_COL_LAST   = CW'(PIXEL_WIDTH - 1);
    localparam logic [RW-1:0] C_ROW_LAST   = RW'(PIXEL_HALFHEIGHT - 1);
    localparam logic [PW-1:0] C_PLANE_LAST = PW'(BCM_BITS - 1);

    localparam logic [2:0] C_ST_IDLE  = 3'd0;
    localparam logic [2:0] C_ST_SHIFT = 3'd1;
    localparam logic [2:0] C_ST_WAIT  = 3'd2;
    localparam logic [2:0] C_ST_BLANK = 3'd3;
    localparam logic [2:0] C_ST_LATCH = 3'd4;
    localparam logic [2:0] C_ST_DRAIN = 3'd5;

    logic [2:0]    r_state;
    logic [2:0]    w_next_state;
    logic          r_phase;       // 0: column presented, 1: pixel_clk high
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [PW-1:0] r_plane;
    logic [RW-1:0] r_row_addr;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_slot;
    logic          w_lit;

    assign w_slot = TW'(OE_BASE_TICKS) << r_plane;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_ST_IDLE:  if (enable) w_next_state = C_ST_SHIFT;
            C_ST_SHIFT: if (r_phase && (r_col == C_COL_LAST)) w_next_state = C_ST_WAIT;
            // Leave while the timer shows its last lit tick so that the
            // blanking cycle lands exactly where the timer reaches zero.
            C_ST_WAIT:  if (r_timer <= TW'(1)) w_next_state = C_ST_BLANK;
            C_ST_BLANK: w_next_state = C_ST_LATCH;
            C_ST_LATCH: w_next_state = enable ? C_ST_SHIFT : C_ST_DRAIN;
            C_ST_DRAIN: if (r_timer == '0) w_next_state = C_ST_IDLE;
            default:    w_next_state = C_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        pixel_clk  = 1'b0;
        row_latch  = 1'b0;
        frame_done = 1'b0;
        busy       = (r_state != C_ST_IDLE);
        oe_n       = ~w_lit;
        case (r_state)
            C_ST_IDLE:  oe_n = 1'b1;
            C_ST_SHIFT: pixel_clk = r_phase;
            C_ST_BLANK: oe_n = 1'b1;
            C_ST_LATCH: begin
                row_latch  = 1'b1;
                frame_done = (r_row == C_ROW_LAST) && (r_plane == C_PLANE_LAST);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift/scan datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_phase    <= 1'b0;
            r_col      <= '0;
            r_row      <= '0;
            r_plane    <= '0;
            r_row_addr <= '0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    // A fresh scan always starts at row 0, plane 0.
                    if (enable) begin
                        r_phase <= 1'b0;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_plane <= '0;
                    end
                end
                C_ST_SHIFT: begin
                    r_phase <= ~r_phase;
                    // Column holds at the last one once the shift completes.
                    if (r_phase && (r_col != C_COL_LAST)) begin
                        r_col <= r_col + CW'(1);
                    end
                end
                C_ST_LATCH: begin
                    r_row_addr <= r_row;
                    r_col      <= '0;
                    r_phase    <= 1'b0;
                    if (r_plane == C_PLANE_LAST) begin
                        r_plane <= '0;
                        r_row   <= (r_row == C_ROW_LAST) ? '0 : r_row + RW'(1);
                    end else begin
                        r_plane <= r_plane + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display timer: free-running down-counter reloaded at each latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= '0;
        end else if (r_state == C_ST_LATCH) begin
            r_timer <= w_slot;
        end else if (r_timer != '0) begin
            r_timer <= r_timer - TW'(1);
        end
    end

`ifdef HUB75_GLOBAL_DIMMING_EN
    // The panel is lit while the timer is above (slot - on_ticks), i.e. for
    // the first on_ticks cycles of the slot.
    logic [TW+7:0] w_prod;
    logic [TW-1:0] w_on_ticks;
    logic [TW-1:0] r_off_thresh;

    assign w_prod     = (TW+8)'(w_slot) * (TW+8)'(brightness);
    assign w_on_ticks = TW'(w_prod >> 8);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_off_thresh <= '0;
        end else if (r_state == C_ST_LATCH) begin
            r_off_thresh <= w_slot - w_on_ticks;
        end
    end

    assign w_lit = (r_timer > r_off_thresh);
`else
    assign w_lit = (r_timer != '0);
`endif

    assign col_addr    = r_col;
    assign shift_row   = r_row;
    assign shift_plane = r_plane;
    assign row_address = r_row_addr;

endmodule
`default_nettype wire

// File: tb/tb_hub75_scan_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hub75_scan_scheduler
//  Description : Self-checking bench for hub75_scan_scheduler. Two instances
//                (display base 10 and a short base of 2 ticks) share the
//                stimulus; a timeline model derived from the scan rules
//                predicts every output on every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hub75_scan_scheduler;

    localparam int W = 4;
    localparam int H = 2;
    localparam int B = 2;
    localparam int OE_A = 10;
    localparam int OE_B = 2;

    logic clk_in  = 1'b0;
    logic reset_n = 1'b0;
    logic enable  = 1'b0;
`ifdef HUB75_GLOBAL_DIMMING_EN
    logic [7:0] brightness  = 8'd128;
    logic [7:0] next_bright = 8'd128;
`endif

    logic [1:0] col_a, col_b;
    logic       row_a, row_b, plane_a, plane_b, raddr_a, raddr_b;
    logic       pclk_a, pclk_b, lat_a, lat_b, oe_a, oe_b, fd_a, fd_b, busy_a, busy_b;
    logic [9:0] out_a, out_b;

    assign out_a = {busy_a, fd_a, lat_a, oe_a, pclk_a, raddr_a, plane_a, row_a, col_a};
    assign out_b = {busy_b, fd_b, lat_b, oe_b, pclk_b, raddr_b, plane_b, row_b, col_b};

    hub75_scan_scheduler #(
        .PIXEL_WIDTH(W), .PIXEL_HALFHEIGHT(H), .BCM_BITS(B), .OE_BASE_TICKS(OE_A)
    ) dut_a (
        .clk_in(clk_in), .reset_n(reset_n), .enable(enable),
`ifdef HUB75_GLOBAL_DIMMING_EN
        .brightness(brightness),
`endif
        .col_addr(col_a), .shift_row(row_a), .shift_plane(plane_a),
        .pixel_clk(pclk_a), .row_latch(lat_a), .oe_n(oe_a),
        .row_address(raddr_a), .frame_done(fd_a), .busy(busy_a)
    );

    hub75_scan_scheduler #(
        .PIXEL_WIDTH(W), .PIXEL_HALFHEIGHT(H), .BCM_BITS(B), .OE_BASE_TICKS(OE_B)
    ) dut_b (
        .clk_in(clk_in), .reset_n(reset_n), .enable(enable),
`ifdef HUB75_GLOBAL_DIMMING_EN
        .brightness(brightness),
`endif
        .col_addr(col_b), .shift_row(row_b), .shift_plane(plane_b),
        .pixel_clk(pclk_b), .row_latch(lat_b), .oe_n(oe_b),
        .row_address(raddr_b), .frame_done(fd_b), .busy(busy_b)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Timeline model: mode 0 idle, 1 running, 2 draining. L is the cycle of
    // the last latch (or of the start), N the slot length started there,
    // on the lit part of that slot, k the number of latches since start.
    int m_mode[2], m_L[2], m_N[2], m_on[2], m_k[2], m_raddr[2];
    int oe_base[2] = '{OE_A, OE_B};

    typedef struct {
        bit         en;
        logic [1:0] col;
        bit         pclk;
        bit         oe_n;
        bit         lat;
    } vec_t;
    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", name, cyc, got, exp);
        end
    endtask

    function automatic int on_ticks(input int slot);
`ifdef HUB75_GLOBAL_DIMMING_EN
        return (slot * int'(brightness)) >> 8;
`else
        return slot;
`endif
    endfunction

    function automatic int period_len(input int i);
        // shift (2W) + one wait cycle minimum, or the whole slot, then blank+latch
        return (((2 * W + 1) > m_N[i]) ? (2 * W + 1) : m_N[i]) + 2;
    endfunction

    function automatic logic [9:0] model_exp(input int i);
        int j, k;
        logic [1:0] col;
        bit pclk, lat, oe_n, fd, busy;
        k = m_k[i];
        j = cyc - m_L[i];
        col = 2'd0; pclk = 1'b0; lat = 1'b0; fd = 1'b0; busy = 1'b1; oe_n = 1'b1;
        case (m_mode[i])
            0: busy = 1'b0;
            1: begin
                if (j <= 2 * W) begin
                    col  = 2'((j - 1) / 2);
                    pclk = ((j - 1) % 2) == 1;
                end else begin
                    col = 2'(W - 1);
                end
                lat  = (j == period_len(i));
                fd   = lat && (k % B == B - 1) && ((k / B) % H == H - 1);
                oe_n = !(j <= m_on[i]);
            end
            default: oe_n = !(j <= m_on[i]);
        endcase
        return {busy, fd, lat, oe_n, pclk, 1'(m_raddr[i]), 1'(k % B), 1'((k / B) % H), col};
    endfunction

    task automatic model_update(input int i);
        int j;
        j = cyc - m_L[i];
        case (m_mode[i])
            0: if (enable) begin
                m_mode[i] = 1; m_L[i] = cyc; m_N[i] = 0; m_on[i] = 0; m_k[i] = 0;
            end
            1: if (j == period_len(i)) begin
                m_raddr[i] = (m_k[i] / B) % H;
                m_N[i]     = oe_base[i] << (m_k[i] % B);
                m_on[i]    = on_ticks(m_N[i]);
                m_k[i]++;
                m_L[i]     = cyc;
                m_mode[i]  = enable ? 1 : 2;
            end
            default: if (j == m_N[i] + 1) m_mode[i] = 0;
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_L[i] = cyc; m_N[i] = 0; m_on[i] = 0; m_k[i] = 0; m_raddr[i] = 0;
        end
    endtask

    task automatic cyc_check();
        check("model_a", out_a, model_exp(0));
        check("model_b", out_b, model_exp(1));
        model_update(0);
        model_update(1);
        cyc++;
    endtask

    // Advance one clock, drive this cycle's inputs, then check the cycle.
    task automatic step(input bit e);
        @(posedge clk_in);
        #1;
        enable = e;
`ifdef HUB75_GLOBAL_DIMMING_EN
        brightness = next_bright;
`endif
        cyc_check();
    endtask

    task automatic do_reset(input bit e);
        reset_n = 1'b0;
        enable  = e;
        repeat (2) @(posedge clk_in);
        #1;
        reset_n = 1'b1;
        model_reset();
        cyc_check();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lows, fd_cnt;
        bit found;
        logic prev1_oe, prev1_lat, prev2_oe;

        // first period after reset: shift 8 cycles, wait, blank, latch
        tbl[0]  = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b1};

        // ---------------- reset state and first shift ----------------
        do_reset(1'b1);
        check("reset_outputs", out_a, 10'h040);
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].en);
            check($sformatf("table_%0d", i), {col_a, pclk_a, oe_a, lat_a},
                  {tbl[i].col, tbl[i].pclk, tbl[i].oe_n, tbl[i].lat});
        end

        // ---------------- slot timing and frame wrap ----------------
        for (int p = 1; p <= 3; p++) begin
            lows = 0; found = 1'b0;
            prev1_oe = 1'bx; prev1_lat = 1'bx; prev2_oe = 1'bx;
            for (int s = 0; s < 60; s++) begin
                step(1'b1);
                if (lat_a) begin
                    found = 1'b1;
                    break;
                end
                prev2_oe  = prev1_oe;
                prev1_oe  = oe_a;
                prev1_lat = lat_a;
                if (!oe_a) lows++;
            end
            check($sformatf("latch_found_%0d", p), 32'(found), 32'd1);
            check($sformatf("slot_low_%0d", p), lows, on_ticks(OE_A << ((p - 1) % B)));
            check($sformatf("blank_before_latch_%0d", p), {prev1_oe, prev1_lat}, 2'b10);
            check($sformatf("lit_before_blank_%0d", p), 32'(prev2_oe),
                  (on_ticks(OE_A << ((p - 1) % B)) >= (OE_A << ((p - 1) % B))) ? 32'd0 : 32'd1);
            check($sformatf("frame_done_%0d", p), 32'(fd_a), (p == 3) ? 32'd1 : 32'd0);
        end
        step(1'b1);
        check("wrap_addr_row_plane", {raddr_a, row_a, plane_a}, 3'b100);

        // ---------------- enable dropped mid-shift ----------------
        do_reset(1'b1);
        fd_cnt = 0;
        for (int s = 0; s < 60 && fd_cnt < 2; s++) begin
            step(1'b1);
            if (lat_a) fd_cnt++;
        end
        check("two_latches", fd_cnt, 2);
        repeat (3) step(1'b1);
        found = 1'b0;
        for (int s = 0; s < 30; s++) begin
            step(1'b0);
            if (lat_a) begin
                found = 1'b1;
                break;
            end
        end
        check("drain_latch_found", 32'(found), 32'd1);
        check("drain_latch_row_plane", {row_a, plane_a}, 2'b10);
        lows = 0; found = 1'b0;
        for (int s = 0; s < 40; s++) begin
            step(1'b0);
            if (!busy_a) begin
                found = 1'b1;
                break;
            end
            if (!oe_a) lows++;
        end
        check("drain_to_idle", 32'(found), 32'd1);
        check("drain_low", lows, on_ticks(OE_A));
        step(1'b1);
        step(1'b1);
        check("restart", {busy_a, col_a, row_a, plane_a}, 5'b10000);

        // ---------------- asynchronous reset mid-shift ----------------
        do_reset(1'b1);
        found = 1'b0;
        for (int s = 0; s < 40; s++) begin
            step(1'b1);
            if (pclk_a && !oe_a) begin
                found = 1'b1;
                break;
            end
        end
        check("lit_shift_found", 32'(found), 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check("async_reset_a", {oe_a, pclk_a, busy_a, lat_a, col_a}, 6'b100000);
        check("async_reset_b", {oe_b, pclk_b, busy_b}, 3'b100);

        // ---------------- randomized run against the model ----------------
        do_reset(1'b1);
        for (int s = 0; s < 2500; s++) begin
`ifdef HUB75_GLOBAL_DIMMING_EN
            next_bright = 8'($urandom_range(0, 255));
`endif
            step($urandom_range(0, 99) < 90);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
